// File: rtl/jpeg_decode_seq_if.sv
// jpeg_decode_seq_if: run-control, ROM feed and MCU status signals of the JPEG decode sequencer
interface jpeg_decode_seq_if #(
  parameter int AW = 16
);
  logic          start;
  logic          abort;
  logic [AW-1:0] rom_addr;
  logic          dec_we;
  logic          dec_next;
  logic          cfg_en;
  logic [12:0]   cfg_mcu_w;
  logic [12:0]   cfg_mcu_h;
  logic          pix_end;
  logic [12:0]   pix_x_mcu;
  logic [12:0]   pix_y_mcu;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [25:0]   mcu_cnt;
  modport master (
    input  start, abort, dec_next, cfg_en, cfg_mcu_w, cfg_mcu_h, pix_end, pix_x_mcu, pix_y_mcu,
    output rom_addr, dec_we, busy, done, err, err_code, mcu_cnt
  );
  modport slave (
    output start, abort, dec_next, cfg_en, cfg_mcu_w, cfg_mcu_h, pix_end, pix_x_mcu, pix_y_mcu,
    input  rom_addr, dec_we, busy, done, err, err_code, mcu_cnt
  );
endinterface

// File: rtl/jpeg_decode_seq.sv
// jpeg_decode_seq: JPEG decode run-control sequencer (start/abort/done FSM, ROM addressing, MCU tracking).
// Optional stall watchdog enabled by defining JPEG_SEQ_WATCHDOG_EN.
module jpeg_decode_seq #(
  parameter int ROM_ADDR_WIDTH = 16,
  parameter int ROM_DEPTH      = 65536,
  parameter int WDOG_CYCLES    = 4096
) (
  input logic clk,
  input logic rst,
  jpeg_decode_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, FEED, DONE, ERR} state_t;
  localparam logic [ROM_ADDR_WIDTH-1:0] LAST = ROM_ADDR_WIDTH'(ROM_DEPTH - 1);
  state_t state, state_n;
  logic [ROM_ADDR_WIDTH-1:0] rom_addr, addr_n;
  logic [25:0] mcu_cnt, cnt_n;
  logic [12:0] mcu_w, mcu_h, w_n, h_n;
  logic [1:0] err_code, code_n;
  logic cfg_seen, seen_n, fin, geo, ovr, wd;
  // final MCU is judged against the geometry latched earlier, never the same-cycle cfg values
  assign fin = cfg_seen && bus.pix_end && bus.pix_x_mcu == mcu_w - 13'd1 && bus.pix_y_mcu == mcu_h - 13'd1;
  assign geo = bus.cfg_en && (bus.cfg_mcu_w == 13'd0 || bus.cfg_mcu_h == 13'd0);
  assign ovr = bus.dec_next && rom_addr == LAST;
`ifdef JPEG_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES);
  logic [WW-1:0] wd_cnt;
  assign wd = state == FEED && !bus.dec_next && !bus.pix_end && wd_cnt == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk)
    wd_cnt <= (rst || state != FEED || bus.dec_next || bus.pix_end) ? '0 : wd_cnt + 1'b1;
`else
  assign wd = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    addr_n  = rom_addr;
    cnt_n   = mcu_cnt;
    seen_n  = cfg_seen;
    w_n     = mcu_w;
    h_n     = mcu_h;
    code_n  = err_code;
    if (state != FEED) begin
      if (bus.start) begin
        state_n = FEED;
        addr_n  = '0;
        cnt_n   = '0;
        seen_n  = 1'b0;
        code_n  = 2'b00;
      end
    end else if (bus.abort) begin
      state_n = IDLE;
    end else begin
      addr_n = (bus.dec_next && !ovr) ? rom_addr + 1'b1 : rom_addr;
      cnt_n  = (cfg_seen && bus.pix_end) ? mcu_cnt + 26'd1 : mcu_cnt;
      seen_n = cfg_seen | bus.cfg_en;
      w_n    = bus.cfg_en ? bus.cfg_mcu_w : mcu_w;
      h_n    = bus.cfg_en ? bus.cfg_mcu_h : mcu_h;
      state_n = fin ? DONE : (geo || ovr || wd) ? ERR : FEED;
      code_n  = fin ? err_code : geo ? 2'b10 : ovr ? 2'b01 : wd ? 2'b11 : err_code;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rom_addr <= '0;
      mcu_cnt  <= '0;
      cfg_seen <= 1'b0;
      mcu_w    <= '0;
      mcu_h    <= '0;
      err_code <= '0;
    end else begin
      rom_addr <= addr_n;
      mcu_cnt  <= cnt_n;
      cfg_seen <= seen_n;
      mcu_w    <= w_n;
      mcu_h    <= h_n;
      err_code <= code_n;
    end
  assign bus.rom_addr = rom_addr;
  assign bus.dec_we   = state == FEED;
  assign bus.busy     = state == FEED;
  assign bus.done     = state == DONE;
  assign bus.err      = state == ERR;
  assign bus.err_code = err_code;
  assign bus.mcu_cnt  = mcu_cnt;
endmodule

// File: tb/tb_jpeg_decode_seq.sv
// tb_jpeg_decode_seq: directed plus randomized checks of jpeg_decode_seq against a behavioural model
module tb_jpeg_decode_seq;
  localparam int DEPTH = 16;
  localparam int WDOG  = 8;
  localparam int S_IDLE = 0, S_FEED = 1, S_DONE = 2, S_ERR = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jpeg_decode_seq_if #(.AW(16)) bus ();
  jpeg_decode_seq #(.ROM_ADDR_WIDTH(16), .ROM_DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  int m_st, m_addr, m_cnt, m_code, m_w, m_h, m_stall;
  bit m_seen;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit s, input bit a, input bit dn, input bit ce, input int w, input int h,
                       input bit pe, input int x, input int y);
    bus.start     = s;
    bus.abort     = a;
    bus.dec_next  = dn;
    bus.cfg_en    = ce;
    bus.cfg_mcu_w = 13'(w);
    bus.cfg_mcu_h = 13'(h);
    bus.pix_end   = pe;
    bus.pix_x_mcu = 13'(x);
    bus.pix_y_mcu = 13'(y);
  endtask
  task automatic model_step();
    bit fin, geo, ovr, wd, dn, pe;
    dn = bus.dec_next;
    pe = bus.pix_end;
    if (rst) begin
      m_st = S_IDLE; m_addr = 0; m_cnt = 0; m_code = 0; m_w = 0; m_h = 0; m_stall = 0; m_seen = 0;
    end else if (m_st != S_FEED) begin
      if (bus.start) begin
        m_st = S_FEED; m_addr = 0; m_cnt = 0; m_code = 0; m_seen = 0; m_stall = 0;
      end
    end else if (bus.abort) begin
      m_st = S_IDLE;
    end else begin
      fin = m_seen && pe && int'(bus.pix_x_mcu) == m_w - 1 && int'(bus.pix_y_mcu) == m_h - 1;
      geo = bus.cfg_en && (bus.cfg_mcu_w == 0 || bus.cfg_mcu_h == 0);
      ovr = dn && m_addr == DEPTH - 1;
      wd = 1'b0;
`ifdef JPEG_SEQ_WATCHDOG_EN
      wd = !dn && !pe && m_stall == WDOG - 1;
`endif
      m_stall = (dn || pe) ? 0 : m_stall + 1;
      if (dn && !ovr) m_addr++;
      if (m_seen && pe) m_cnt = (m_cnt + 1) % (1 << 26);
      if (bus.cfg_en) begin
        m_seen = 1;
        m_w = int'(bus.cfg_mcu_w);
        m_h = int'(bus.cfg_mcu_h);
      end
      if (fin) m_st = S_DONE;
      else if (geo) begin m_st = S_ERR; m_code = 2; end
      else if (ovr) begin m_st = S_ERR; m_code = 1; end
      else if (wd) begin m_st = S_ERR; m_code = 3; end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rom_addr", bus.rom_addr, m_addr);
    check("dec_we", bus.dec_we, m_st == S_FEED);
    check("busy", bus.busy, m_st == S_FEED);
    check("done", bus.done, m_st == S_DONE);
    check("err", bus.err, m_st == S_ERR);
    check("err_code", bus.err_code, m_code);
    check("mcu_cnt", bus.mcu_cnt, m_cnt);
  endtask
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    check("rst_addr", bus.rom_addr, 0);
    check("rst_we", bus.dec_we, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("start_we", bus.dec_we, 1);
    check("start_busy", bus.busy, 1);
    check("start_addr", bus.rom_addr, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    check("addr10", bus.rom_addr, 10);
    idle(3);
    check("addr_hold", bus.rom_addr, 10);
    drive(0, 0, 0, 1, 2, 2, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, k % 2, k / 2);
      tick();
      if (k < 3) idle(1);
    end
    check("mcu4", bus.mcu_cnt, 4);
    check("done_set", bus.done, 1);
    check("done_we", bus.dec_we, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("ovr_addr", bus.rom_addr, DEPTH - 1);
    check("ovr_err", bus.err, 1);
    check("ovr_code", bus.err_code, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("restart_busy", bus.busy, 1);
    check("restart_err", bus.err, 0);
    drive(0, 0, 0, 1, 1, 1, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 3, 0, 0, 0);
    tick();
    check("geo_code", bus.err_code, 2);
`ifdef JPEG_SEQ_WATCHDOG_EN
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(7);
    check("wd_not_yet", bus.busy, 1);
    idle(1);
    check("wd_code", bus.err_code, 3);
`endif
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
